// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC sequencer with a hardware return-address stack.
// Evaluates one control op (JMP, BEQ, BNE, CALL, RET, HALT, NOP) per accepted
// handshake and presents the resulting PC to fetch one cycle later.
// Optional macro PCSEQ_TRAP_EN: a stack fault vectors to TRAP_VECTOR through a
// one-cycle TRAP state; without it a fault acts as NOP and only sets err.
module pc_sequencer #(
    parameter int              PC_W         = 19,
    parameter int              DEPTH        = 16,
    parameter int              SP_W         = $clog2(DEPTH) + 1,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = PC_W'(8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [3:0]      ctrl_op,
    input  logic [PC_W-1:0] addr,
    input  logic [PC_W-1:0] r1,
    input  logic [PC_W-1:0] r2,
    input  logic            fetch_ready,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic [SP_W-1:0] sp,
    output logic            stk_full,
    output logic            stk_empty,
    output logic            err,
    output logic            halted
);

    localparam int IDX_W = SP_W - 1;

    localparam logic [3:0] OP_JMP  = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b0001;
    localparam logic [3:0] OP_BNE  = 4'b0010;
    localparam logic [3:0] OP_CALL = 4'b0011;
    localparam logic [3:0] OP_RET  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b0101;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_TRAP} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              pc_valid_q, run_q, halted_q;
    logic [PC_W-1:0]   stack_q [DEPTH];

    logic              accept;
    logic              push;
    logic              fault;
    logic              full, empty;
    logic [PC_W-1:0]   pc_inc;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    // run_q is the registered "state is RUN" flag, so op_ready only adds fetch_ready
    assign op_ready  = run_q && fetch_ready;
    assign accept    = op_valid && op_ready;
    assign full      = (sp_q == SP_W'(DEPTH));
    assign empty     = (sp_q == '0);
    assign pc_inc    = pc_q + PC_W'(1);
    assign wr_idx    = sp_q[IDX_W-1:0];
    assign rd_idx    = wr_idx - IDX_W'(1);

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign sp        = sp_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign err       = err_q;
    assign halted    = halted_q;

    // Next-state decode: one op evaluated per accepted handshake, everything holds otherwise
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (accept) begin
                    case (ctrl_op)
                        OP_JMP:  pc_d = addr;
                        OP_BEQ:  pc_d = (r1 == r2) ? addr : pc_inc;
                        OP_BNE:  pc_d = (r1 != r2) ? addr : pc_inc;
                        OP_CALL: begin
                            if (full) begin
                                fault = 1'b1;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + SP_W'(1);
                                pc_d = addr;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                fault = 1'b1;
                            end else begin
                                sp_d = sp_q - SP_W'(1);
                                pc_d = stack_q[rd_idx];
                            end
                        end
                        OP_HALT: state_d = S_HALT;
                        default: pc_d = pc_inc;
                    endcase
                    if (fault) begin
                        err_d = 1'b1;
`ifdef PCSEQ_TRAP_EN
                        pc_d    = TRAP_VECTOR;
                        state_d = S_TRAP;
`else
                        pc_d    = pc_inc;
`endif
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            // TRAP re-asserts the vector and blocks ops for exactly one cycle
            S_TRAP: begin
                pc_d    = TRAP_VECTOR;
                state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Control state and registered status outputs; reset wins over any op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VECTOR;
            sp_q       <= '0;
            err_q      <= 1'b0;
            pc_valid_q <= 1'b0;
            run_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
            pc_valid_q <= (state_d == S_RUN) || (state_d == S_HALT);
            run_q      <= (state_d == S_RUN);
            halted_q   <= (state_d == S_HALT);
        end
    end

    // Return-address storage: written only by a non-faulting CALL, contents not reset
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. A behavioural model
// predicts pc/sp/err/halted/pc_valid for every cycle driven; the prediction is
// queued and compared once the DUT has clocked the same cycle.
module tb_pc_sequencer;

    localparam int          PC_W  = 19;
    localparam int          DEPTH = 16;
    localparam int          SP_W  = 5;
    localparam logic [18:0] TRAPV = 19'd8;

    localparam logic [3:0] JMP = 4'd0, BEQ = 4'd1, BNE = 4'd2, CALL = 4'd3,
                           RET = 4'd4, HALT = 4'd5, NOP = 4'd6;

    localparam int ST_BOOT = 0, ST_RUN = 1, ST_HALT = 2, ST_TRAP = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [3:0]      ctrl_op = 4'd0;
    logic [PC_W-1:0] addr = '0, r1 = '0, r2 = '0;
    logic            fetch_ready = 1'b0;
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic [SP_W-1:0] sp;
    logic            stk_full, stk_empty, err, halted;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .ctrl_op(ctrl_op), .addr(addr), .r1(r1), .r2(r2),
        .fetch_ready(fetch_ready), .pc(pc), .pc_valid(pc_valid), .sp(sp),
        .stk_full(stk_full), .stk_empty(stk_empty), .err(err), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [18:0] pc;
        int          sp;
        bit          err;
        bit          halted;
        bit          pcv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    logic [18:0] m_pc;
    int          m_sp;
    bit          m_err;
    int          m_st;
    logic [18:0] m_stk [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_fault();
        m_err = 1'b1;
`ifdef PCSEQ_TRAP_EN
        m_pc = TRAPV;
        m_st = ST_TRAP;
`else
        m_pc = m_pc + 19'd1;
`endif
    endfunction

    // Drive one cycle of stimulus, predict its outcome, then compare after the edge
    task automatic step(input bit r, input bit v, input logic [3:0] op,
                        input logic [18:0] a, input logic [18:0] x, input logic [18:0] y,
                        input bit fr, input string tag);
        exp_t e;
        bit   acc;
        rst = r; op_valid = v; ctrl_op = op; addr = a; r1 = x; r2 = y; fetch_ready = fr;
        #1;
        chk({tag, ".rdy"}, 32'(op_ready), 32'((m_st == ST_RUN) && fr));
        acc = v && fr && (m_st == ST_RUN);
        if (r) begin
            m_pc = '0; m_sp = 0; m_err = 1'b0; m_st = ST_BOOT;
        end else begin
            case (m_st)
                ST_BOOT: m_st = ST_RUN;
                ST_TRAP: begin m_st = ST_RUN; m_pc = TRAPV; end
                ST_RUN: if (acc) begin
                    case (op)
                        JMP:  m_pc = a;
                        BEQ:  m_pc = (x == y) ? a : m_pc + 19'd1;
                        BNE:  m_pc = (x != y) ? a : m_pc + 19'd1;
                        CALL: if (m_sp == DEPTH) model_fault();
                              else begin m_stk[m_sp] = m_pc + 19'd1; m_sp++; m_pc = a; end
                        RET:  if (m_sp == 0) model_fault();
                              else begin m_sp--; m_pc = m_stk[m_sp]; end
                        HALT: m_st = ST_HALT;
                        default: m_pc = m_pc + 19'd1;
                    endcase
                end
                default: ;
            endcase
        end
        e.tag = tag; e.pc = m_pc; e.sp = m_sp; e.err = m_err;
        e.halted = (m_st == ST_HALT);
        e.pcv = (m_st == ST_RUN) || (m_st == ST_HALT);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"},    32'(pc),        32'(e.pc));
        chk({e.tag, ".sp"},    32'(sp),        32'(e.sp));
        chk({e.tag, ".err"},   32'(err),       32'(e.err));
        chk({e.tag, ".halt"},  32'(halted),    32'(e.halted));
        chk({e.tag, ".pcv"},   32'(pc_valid),  32'(e.pcv));
        chk({e.tag, ".full"},  32'(stk_full),  32'(e.sp == DEPTH));
        chk({e.tag, ".empty"}, 32'(stk_empty), 32'(e.sp == 0));
    endtask

    task automatic op1(input logic [3:0] op, input logic [18:0] a, input string tag);
        step(1'b0, 1'b1, op, a, 19'd0, 19'd1, 1'b1, tag);
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b1, CALL, 19'd99, 19'd0, 19'd0, 1'b1, tag);
        step(1'b1, 1'b1, JMP, 19'd77, 19'd0, 19'd0, 1'b1, tag);
        step(1'b0, 1'b1, JMP, 19'd33, 19'd0, 19'd0, 1'b1, {tag, ".boot"});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pc = '0; m_sp = 0; m_err = 1'b0; m_st = ST_BOOT;
        @(posedge clk);
        #1;
        do_reset("rst");
        step(1'b0, 1'b0, NOP, 19'd0, 19'd0, 19'd0, 1'b0, "rdy_lo");
        step(1'b0, 1'b0, NOP, 19'd0, 19'd0, 19'd0, 1'b1, "rdy_hi");

        // jumps and branches
        op1(JMP, 19'd50, "jmp50");
        step(1'b0, 1'b1, BEQ, 19'd50, 19'd10, 19'd10, 1'b1, "beq_t");
        step(1'b0, 1'b1, BEQ, 19'd90, 19'd10, 19'd20, 1'b1, "beq_nt");
        step(1'b0, 1'b1, BNE, 19'd123, 19'd10, 19'd20, 1'b1, "bne_t");
        step(1'b0, 1'b1, BNE, 19'd5, 19'h7FFFF, 19'h7FFFF, 1'b1, "bne_nt");
        op1(4'b1111, 19'd0, "nop_f");

        // call / return, including nesting
        op1(JMP, 19'd10, "jmp10");
        op1(CALL, 19'd50, "call50");
        op1(RET, 19'd0, "ret11");
        op1(JMP, 19'd10, "jmp10b");
        op1(CALL, 19'd50, "nc1");
        op1(CALL, 19'd60, "nc2");
        op1(CALL, 19'd100, "nc3");
        step(1'b0, 1'b1, CALL, 19'd400, 19'd0, 19'd0, 1'b0, "stall");
        op1(RET, 19'd0, "nr61");
        op1(RET, 19'd0, "nr51");
        op1(RET, 19'd0, "nr11");

        // underflow, then wrap-around of pc+1
        op1(RET, 19'd0, "underflow");
        op1(JMP, 19'h7FFFF, "jmpmax");
        op1(NOP, 19'd0, "wrap");

        // fill the stack to DEPTH, then overflow
        do_reset("rst2");
        for (int i = 0; i < DEPTH; i++) op1(CALL, 19'(200 + 3 * i), $sformatf("fill%0d", i));
        op1(CALL, 19'd999, "overflow");
        op1(NOP, 19'd0, "post_ovf");
        op1(RET, 19'd0, "ret_top");

        // reset with three stack entries
        do_reset("rst3");
        op1(CALL, 19'd20, "c3a");
        op1(CALL, 19'd30, "c3b");
        op1(CALL, 19'd40, "c3c");
        do_reset("rst_stk");
        op1(RET, 19'd0, "empty_after_rst");

        // randomised traffic against the model (HALT excluded)
        do_reset("rst4");
        for (int i = 0; i < 250; i++) begin
            logic [3:0]  op;
            logic [18:0] x;
            op = 4'($urandom_range(0, 15));
            if (op == HALT) op = RET;
            x  = 19'($urandom_range(0, 3));
            step(1'b0, $urandom_range(0, 3) != 0, op, 19'($urandom),
                 x, ($urandom_range(0, 1) != 0) ? x : 19'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $sformatf("rnd%0d", i));
        end

        // halt: later ops ignored, only reset leaves
        do_reset("rst5");
        op1(CALL, 19'd70, "pre_halt");
        op1(HALT, 19'd0, "halt");
        op1(JMP, 19'd5, "halted_jmp");
        op1(RET, 19'd0, "halted_ret");
        do_reset("rst_halt");
        op1(JMP, 19'd44, "after_halt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
